// File: rtl/apb_master_nslv.sv
// APB master with an integrated address decoder serving NUM_SLV slaves.
// A ready/valid request port feeds a three-state IDLE/SETUP/ACCESS FSM.
// The top SEL_W address bits pick the slave. Features:
//   - wait-state support and PSLVERR propagation,
//   - a watchdog that aborts stalled transfers,
//   - an 8-bit saturating count of errored transfers.
module apb_master_nslv #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic                      trf_valid,
  output logic                      trf_ready,
  input  logic                      trf_write,
  input  logic [ADDR_W-1:0]         trf_addr,
  input  logic [DATA_W-1:0]         trf_wdata,
  output logic                      trf_done,
  output logic                      trf_err,
  output logic [DATA_W-1:0]         trf_rdata,
  output logic [7:0]                err_cnt,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SEL_W = $clog2(NUM_SLV);
  // A zero TIMEOUT still needs a legal one-bit counter; the compare is gated off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    idx;
  logic [CNT_W-1:0]    wait_cnt;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_hit;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_SLV-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Only the addressed slave's handshake and data are looked at.
  always_comb begin
    sel_ready = pready[idx];
    sel_err   = pslverr[idx];
    sel_rdata = prdata[int'(idx)*DATA_W +: DATA_W];
    tmo_hit   = (TIMEOUT != 0) && (wait_cnt == TMO_LIM);
  end

  // Transfer FSM; all bus and completion outputs are registered here.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state     <= ST_IDLE;
      trf_ready <= 1'b1;
      trf_done  <= 1'b0;
      trf_err   <= 1'b0;
      trf_rdata <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
    end else begin
      trf_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trf_valid) begin
            paddr     <= trf_addr;
            pwdata    <= trf_wdata;
            pwrite    <= trf_write;
            idx       <= trf_addr[ADDR_W-1 -: SEL_W];
            psel      <= onehot(trf_addr[ADDR_W-1 -: SEL_W]);
            wait_cnt  <= '0;
            trf_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            // A ready on the limit cycle wins over the watchdog.
            psel      <= '0;
            penable   <= 1'b0;
            trf_done  <= 1'b1;
            trf_err   <= sel_err;
            trf_ready <= 1'b1;
            if (!pwrite) begin
              trf_rdata <= sel_err ? '0 : sel_rdata;
            end
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            psel      <= '0;
            penable   <= 1'b0;
            trf_done  <= 1'b1;
            trf_err   <= 1'b1;
            trf_ready <= 1'b1;
            if (!pwrite) begin
              trf_rdata <= '0;
            end
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel      <= '0;
          penable   <= 1'b0;
          trf_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Errored completions are counted once each, sticking at 255.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      err_cnt <= '0;
    end else if (trf_done && trf_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: directed scenarios plus randomized transfers
// checked against a transaction-level model of latency, error and read data.
module tb_apb_master_nslv;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        prst;
  logic        trf_valid, trf_ready, trf_write;
  logic [7:0]  trf_addr, trf_wdata;
  logic        trf_done, trf_err;
  logic [7:0]  trf_rdata, err_cnt;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr, pwdata;
  logic [31:0] prdata;
  logic [3:0]  pready, pslverr;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  int         m_lat;
  logic       m_err;
  logic [7:0] m_rdata  = 8'h00;
  int         m_errcnt = 0;

  apb_master_nslv #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prst(prst),
    .trf_valid(trf_valid), .trf_ready(trf_ready), .trf_write(trf_write),
    .trf_addr(trf_addr), .trf_wdata(trf_wdata),
    .trf_done(trf_done), .trf_err(trf_err), .trf_rdata(trf_rdata),
    .err_cnt(err_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // A transfer whose slave answers after `waits` low ACCESS cycles (never if
  // waits exceeds the watchdog limit) completes 3+waits cycles after accept,
  // or 3+TMO cycles with an error when the watchdog fires.
  function automatic void model_xfer(input logic wr, input int waits, input logic serr,
                                     input logic [7:0] slice);
    logic tmo;
    tmo   = (TMO != 0) && (waits > TMO);
    m_lat = tmo ? 3 + TMO : 3 + waits;
    m_err = tmo | serr;
    if (!wr) m_rdata = m_err ? 8'h00 : slice;
    if (m_err && m_errcnt < 255) m_errcnt++;
  endfunction

  // Drives one request and plays the addressed slave; other slaves get noise.
  // Returns observations only. Starts and ends at a falling edge.
  task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          input int waits, input logic serr, input logic [7:0] slice,
                          output int lat, output logic err, output logic [7:0] rdata,
                          output logic [3:0] setup_psel, output int bus_bad,
                          output logic done_after, output logic [7:0] ecnt_after);
    int sidx;
    int acc;
    logic [3:0] oh;
    sidx = int'(addr[7:6]);
    oh   = 4'b0001 << sidx;
    lat = -1; err = 1'bx; rdata = 8'hxx; setup_psel = 4'hx; bus_bad = 0; acc = 0;
    trf_valid = 1'b1; trf_write = wr; trf_addr = addr; trf_wdata = wd;
    for (int c = 1; c <= TMO + 12; c++) begin
      @(negedge pclk);
      trf_valid = 1'b0;
      if (c == 1) setup_psel = psel;
      if (trf_done) begin
        lat = c; err = trf_err; rdata = trf_rdata;
        if (psel !== 4'b0000 || penable !== 1'b0 || trf_ready !== 1'b1) bus_bad++;
        break;
      end
      if (paddr !== addr || pwdata !== wd || pwrite !== wr || psel !== oh) bus_bad++;
      if (penable !== (c >= 2) || trf_ready !== 1'b0) bus_bad++;
      pready  = 4'($urandom);
      pslverr = 4'($urandom);
      prdata  = $urandom;
      pready[sidx] = 1'b0;
      if (penable) begin
        pready[sidx]  = (acc == waits);
        pslverr[sidx] = (acc == waits) ? serr : 1'($urandom);
        acc++;
      end
      prdata[sidx*8 +: 8] = slice;
    end
    @(negedge pclk);
    pready = 4'b0000; pslverr = 4'b0000;
    done_after = trf_done;
    ecnt_after = err_cnt;
  endtask

  task automatic test_reset();
    prst = 1'b1; trf_valid = 1'b0; trf_write = 1'b0; trf_addr = 8'h00; trf_wdata = 8'h00;
    prdata = '0; pready = '0; pslverr = '0;
    repeat (2) @(negedge pclk);
    total++; if (psel !== 4'b0000) begin bad++; $display("FAIL rst_psel: got %b want 0000", psel); end
    total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable: got %b want 0", penable); end
    total++; if ({pwrite, paddr, pwdata} !== 17'h0) begin bad++; $display("FAIL rst_bus: got %h want 0", {pwrite, paddr, pwdata}); end
    total++; if ({trf_done, trf_err, trf_rdata} !== 10'h0) begin bad++; $display("FAIL rst_trf: got %h want 0", {trf_done, trf_err, trf_rdata}); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rst_errcnt: got %0d want 0", err_cnt); end
    prst = 1'b0;
    @(negedge pclk);
    total++; if (trf_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", trf_ready); end
  endtask

  task automatic test_zero_wait_write();
    int lat, bb; logic err, dn; logic [7:0] rd, ec; logic [3:0] sp;
    run_xfer(1'b1, 8'h85, 8'h3C, 0, 1'b0, 8'h5A, lat, err, rd, sp, bb, dn, ec);
    model_xfer(1'b1, 0, 1'b0, 8'h5A);
    total++; if (sp !== 4'b0100) begin bad++; $display("FAIL zw_setup_psel: got %b want 0100", sp); end
    total++; if (lat != m_lat) begin bad++; $display("FAIL zw_latency: got %0d want %0d", lat, m_lat); end
    total++; if (err !== m_err) begin bad++; $display("FAIL zw_err: got %b want %b", err, m_err); end
    total++; if (rd !== m_rdata) begin bad++; $display("FAIL zw_rdata: got %h want %h", rd, m_rdata); end
    total++; if (bb != 0) begin bad++; $display("FAIL zw_bus: got %0d violations want 0", bb); end
    total++; if (dn !== 1'b0) begin bad++; $display("FAIL zw_done_pulse: got %b want 0", dn); end
  endtask

  task automatic test_wait_read();
    int lat, bb; logic err, dn; logic [7:0] rd, ec; logic [3:0] sp;
    run_xfer(1'b0, 8'h4A, 8'h00, 3, 1'b0, 8'hA5, lat, err, rd, sp, bb, dn, ec);
    model_xfer(1'b0, 3, 1'b0, 8'hA5);
    total++; if (sp !== 4'b0010) begin bad++; $display("FAIL wr_setup_psel: got %b want 0010", sp); end
    total++; if (lat != m_lat) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, m_lat); end
    total++; if (err !== m_err) begin bad++; $display("FAIL wr_err: got %b want %b", err, m_err); end
    total++; if (rd !== m_rdata) begin bad++; $display("FAIL wr_rdata: got %h want %h", rd, m_rdata); end
    total++; if (bb != 0) begin bad++; $display("FAIL wr_bus_stable: got %0d violations want 0", bb); end
  endtask

  task automatic test_slverr_read();
    int lat, bb; logic err, dn; logic [7:0] rd, ec; logic [3:0] sp;
    run_xfer(1'b0, 8'hD3, 8'h00, 1, 1'b1, 8'h77, lat, err, rd, sp, bb, dn, ec);
    model_xfer(1'b0, 1, 1'b1, 8'h77);
    total++; if (lat != m_lat) begin bad++; $display("FAIL se_latency: got %0d want %0d", lat, m_lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL se_err: got %b want 1", err); end
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL se_rdata: got %h want 00", rd); end
    total++; if (ec !== 8'(m_errcnt)) begin bad++; $display("FAIL se_errcnt: got %0d want %0d", ec, m_errcnt); end
    total++; if (bb != 0) begin bad++; $display("FAIL se_bus: got %0d violations want 0", bb); end
  endtask

  task automatic test_timeout_boundary();
    int lat, bb; logic err, dn; logic [7:0] rd, ec; logic [3:0] sp;
    run_xfer(1'b0, 8'h21, 8'h00, TMO, 1'b0, 8'hC3, lat, err, rd, sp, bb, dn, ec);
    model_xfer(1'b0, TMO, 1'b0, 8'hC3);
    total++; if (lat != m_lat) begin bad++; $display("FAIL tb_latency: got %0d want %0d", lat, m_lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tb_err: got %b want 0", err); end
    total++; if (rd !== m_rdata) begin bad++; $display("FAIL tb_rdata: got %h want %h", rd, m_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ps [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] ps [6];
    logic [7:0] slice3, rd6;
    logic rdy3, err6, multi;
    int done_at [$];
    multi = 1'b0;
    pready = 4'b1111; pslverr = 4'b0000; prdata = $urandom;
    slice3 = prdata[31:24];
    trf_valid = 1'b1; trf_write = 1'b1; trf_addr = 8'h10; trf_wdata = 8'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge pclk);
      ps[c-1] = psel;
      if ($countones(psel) > 1) multi = 1'b1;
      if (trf_done) done_at.push_back(c);
      if (c == 3) begin rdy3 = trf_ready; trf_write = 1'b0; trf_addr = 8'hC0; end
      if (c == 6) begin trf_valid = 1'b0; rd6 = trf_rdata; err6 = trf_err; end
    end
    pready = 4'b0000;
    model_xfer(1'b1, 0, 1'b0, 8'h00);
    model_xfer(1'b0, 0, 1'b0, slice3);
    for (int i = 0; i < 6; i++) begin
      total++; if (ps[i] !== exp_ps[i]) begin bad++; $display("FAIL b2b_psel[%0d]: got %b want %b", i, ps[i], exp_ps[i]); end
    end
    total++; if (multi) begin bad++; $display("FAIL b2b_onehot: got multiple psel bits want at most one"); end
    total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL b2b_ready_in_done: got %b want 1", rdy3); end
    total++; if (done_at.size() != 2 || done_at[0] != 3 || done_at[1] != 6) begin
      bad++; $display("FAIL b2b_done_cycles: got %0d pulses want 2 at cycles 3 and 6", done_at.size());
    end
    total++; if (rd6 !== m_rdata || err6 !== 1'b0) begin bad++; $display("FAIL b2b_rdata: got %h/%b want %h/0", rd6, err6, m_rdata); end
    @(negedge pclk);
  endtask

  task automatic test_random();
    int lat, bb, waits, r; logic err, dn, wr, serr; logic [7:0] rd, ec, addr, wd, slice; logic [3:0] sp;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); addr = 8'($urandom); wd = 8'($urandom); slice = 8'($urandom);
      serr = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      waits = (r < 6) ? r : (r == 6) ? TMO : (r == 7) ? TMO + 5 : $urandom_range(0, 2);
      run_xfer(wr, addr, wd, waits, serr, slice, lat, err, rd, sp, bb, dn, ec);
      model_xfer(wr, waits, serr, slice);
      total++; if (lat != m_lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, m_lat); end
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", i, err, m_err); end
      total++; if (rd !== m_rdata) begin bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, m_rdata); end
      total++; if (bb != 0) begin bad++; $display("FAIL rnd%0d_bus: got %0d violations want 0", i, bb); end
      total++; if (dn !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_pulse: got %b want 0", i, dn); end
      total++; if (ec !== 8'(m_errcnt)) begin bad++; $display("FAIL rnd%0d_errcnt: got %0d want %0d", i, ec, m_errcnt); end
    end
  endtask

  task automatic test_timeout();
    int lat, bb; logic err, dn; logic [7:0] rd, ec; logic [3:0] sp;
    for (int i = 0; i < 300; i++) begin
      run_xfer(1'($urandom), 8'($urandom), 8'($urandom), 9999, 1'b0, 8'($urandom),
               lat, err, rd, sp, bb, dn, ec);
      model_xfer(1'b1, 9999, 1'b0, 8'h00);
      total++; if (lat != m_lat) begin bad++; $display("FAIL to%0d_latency: got %0d want %0d", i, lat, m_lat); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL to%0d_err: got %b want 1", i, err); end
      if (i == 0) begin
        total++; if (bb != 0) begin bad++; $display("FAIL to_penable_hold: got %0d violations want 0", bb); end
      end
    end
    total++; if (ec !== 8'(m_errcnt) || m_errcnt != 255) begin bad++; $display("FAIL to_errcnt_sat: got %0d want 255", ec); end
    m_rdata = trf_rdata;
  endtask

  task automatic test_reset_mid();
    logic seen, rdy_ok, pen;
    prdata = $urandom; pready = 4'b0000; pslverr = 4'b0000;
    trf_valid = 1'b1; trf_write = 1'b0; trf_addr = 8'h7F; trf_wdata = 8'h00;
    @(negedge pclk); trf_valid = 1'b0;
    @(negedge pclk); pen = penable;
    total++; if (pen !== 1'b1) begin bad++; $display("FAIL rm_in_access: got %b want 1", pen); end
    #2 prst = 1'b1;
    #1;
    total++; if (psel !== 4'b0000 || penable !== 1'b0) begin bad++; $display("FAIL rm_bus_idle: got %b/%b want 0000/0", psel, penable); end
    total++; if (trf_done !== 1'b0) begin bad++; $display("FAIL rm_done: got %b want 0", trf_done); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rm_errcnt: got %0d want 0", err_cnt); end
    @(negedge pclk); prst = 1'b0;
    m_errcnt = 0; m_rdata = 8'h00;
    seen = 1'b0; rdy_ok = 1'b1;
    pready = 4'b1111;
    repeat (6) begin
      @(negedge pclk);
      if (trf_done !== 1'b0) seen = 1'b1;
      if (trf_ready !== 1'b1) rdy_ok = 1'b0;
    end
    pready = 4'b0000;
    total++; if (seen) begin bad++; $display("FAIL rm_no_done: got done pulse want none"); end
    total++; if (!rdy_ok) begin bad++; $display("FAIL rm_ready: got 0 want 1"); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr_read();
    test_timeout_boundary();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
